// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl
//   Sequences the TestMode scan chain built from the DES round registers.
//   The host preloads a pattern buffer and issues an operation:
//     DUMP (op=0): shift the chain out into the readback buffer.
//     TEST (op=1): shift the pattern in, capture once, then shift out.
//   During shift-out the pattern is shifted back in, so the chain holds the
//   pattern afterwards. The host then reads the readback buffer.
//
//   Optional feature macro: SCAN_SIG_EN
//     defined   : sig = XOR of all readback words, accumulated per word
//     undefined : sig tied to 0
//
// Ports
//   clk, rst              clock / synchronous active-high reset
//   start, op             1-cycle op request (accepted only in IDLE), op select
//   wr_en/wr_addr/wr_data pattern-buffer write (ignored while busy)
//   rd_addr, rd_data      readback word read, registered, 1-cycle latency
//   busy, done            activity flag / sticky completion flag
//   test_mode, scan_in    chain TestMode and SIN drives
//   scan_out              chain S_OUT, valid while test_mode=1
//   sig                   readback signature
module scan_chain_ctrl #(
  parameter int REG_W    = 32,
  parameter int NUM_REGS = 16,
  parameter int AW       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [REG_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [REG_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             test_mode,
  output logic             scan_in,
  input  logic             scan_out,
  output logic [REG_W-1:0] sig
);

  localparam int CHAIN_LEN = REG_W * NUM_REGS;
  localparam int CW        = $clog2(CHAIN_LEN);
  localparam int BW        = $clog2(REG_W);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last;
  logic             start_ok;
  logic             wr_ok;
  logic             shift_d;
  logic             scan_in_d;

  logic [REG_W-1:0] pat_mem [NUM_REGS];
  logic [REG_W-1:0] rb_mem  [NUM_REGS];
  logic [REG_W-1:0] pat_word_d;

  // Shift cycle k addresses word k/REG_W, bit REG_W-1-(k%REG_W): MSB first.
  logic [AW-1:0]    word_q, word_d;
  logic [BW-1:0]    bit_q, bit_d;

  assign word_q = cnt_q[CW-1:BW];
  assign bit_q  = BW'(REG_W-1) - cnt_q[BW-1:0];
  assign word_d = cnt_d[CW-1:BW];
  assign bit_d  = BW'(REG_W-1) - cnt_d[BW-1:0];

  assign last  = (cnt_q == CW'(CHAIN_LEN-1));
  assign busy  = (state_q != IDLE) && (state_q != DONE);
  assign wr_ok = wr_en && !busy;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    start_ok = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = op ? SHIFT_IN : SHIFT_OUT;
          cnt_d    = '0;
        end
      end
      SHIFT_IN: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end
      end
      CAPTURE: begin
        state_d = SHIFT_OUT;
        cnt_d   = '0;
      end
      SHIFT_OUT: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // scan_in is registered alongside test_mode, so it is computed from the
  // next counter value. A write landing on the same edge as start is
  // forwarded so the first shifted bits already see the new word.
  always_comb begin
    pat_word_d = pat_mem[word_d];
    if (wr_ok && (wr_addr == word_d)) pat_word_d = wr_data;
  end

  assign shift_d   = (state_d == SHIFT_IN) || (state_d == SHIFT_OUT);
  assign scan_in_d = shift_d & pat_word_d[bit_d];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      test_mode <= 1'b0;
      scan_in   <= 1'b0;
      done      <= 1'b0;
      rd_data   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      test_mode <= shift_d;
      scan_in   <= scan_in_d;
      if (start_ok)
        done <= 1'b0;
      else if ((state_q == SHIFT_OUT) && last)
        done <= 1'b1;
      rd_data   <= rb_mem[rd_addr];
    end
  end

  // Buffers are storage only and are never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_ok) pat_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (state_q == SHIFT_OUT) rb_mem[word_q][bit_q] <= scan_out;
  end

`ifdef SCAN_SIG_EN
  // The last bit of a word arrives on scan_out in the same cycle the word
  // completes, so it is merged in directly rather than read from rb_mem.
  always_ff @(posedge clk) begin
    if (rst)
      sig <= '0;
    else if (start_ok)
      sig <= '0;
    else if ((state_q == SHIFT_OUT) && (cnt_q[BW-1:0] == BW'(REG_W-1)))
      sig <= sig ^ {rb_mem[word_q][REG_W-1:1], scan_out};
  end
`else
  assign sig = '0;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
module tb_scan_chain_ctrl;
  localparam int REG_W = 32;
  localparam int NREG  = 16;
  localparam int AW    = 4;
  localparam int CL    = REG_W * NREG;

  logic             clk = 1'b0;
  logic             rst, start, op, wr_en;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [REG_W-1:0] wr_data, rd_data, sig;
  logic             busy, done, test_mode, scan_in, scan_out;

  scan_chain_ctrl #(.REG_W(REG_W), .NUM_REGS(NREG), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .test_mode(test_mode),
    .scan_in(scan_in), .scan_out(scan_out), .sig(sig)
  );

  always #5 clk = ~clk;

  // Behavioural chain: 512-bit shift register, word 0 MSB at the S_OUT end.
  // While TestMode=0 it captures RDFF: mode 0 = preset values,
  // mode 1 = Q ^ xmask per register, mode 2 = hold.
  logic [CL-1:0]    ch = '0;
  logic [REG_W-1:0] preset [NREG];
  logic [REG_W-1:0] xmask = '0;
  int               mode = 2;

  always @(posedge clk) begin
    if (test_mode)
      ch <= {ch[CL-2:0], scan_in};
    else if (mode == 0) begin
      for (int w = 0; w < NREG; w++) ch[CL-1-REG_W*w -: REG_W] <= preset[w];
    end else if (mode == 1)
      ch <= ch ^ {NREG{xmask}};
  end

  assign scan_out = ch[CL-1];

  int checks = 0;
  int errors = 0;
  logic [REG_W-1:0] exp_w [NREG];
  logic [REG_W-1:0] pat_w [NREG];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic logic [REG_W-1:0] sig_expect();
    logic [REG_W-1:0] s = '0;
`ifdef SCAN_SIG_EN
    for (int i = 0; i < NREG; i++) s ^= exp_w[i];
`endif
    return s;
  endfunction

  task automatic write_word(input logic [AW-1:0] a, input logic [REG_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic write_pattern();
    for (int i = 0; i < NREG; i++) write_word(AW'(i), pat_w[i]);
  endtask

  task automatic check_readback(input string tag);
    logic [REG_W-1:0] d;
    for (int i = 0; i < NREG; i++) begin
      rd_addr = AW'(i);
      @(negedge clk);
      d = rd_data;
      check($sformatf("%s_word%0d", tag, i), d, exp_w[i]);
    end
    check({tag, "_sig"}, sig, sig_expect());
  endtask

  // Issues an op and follows it to completion. pulse_at >= 0 injects a
  // start + write(addr 3) pulse at that shift cycle; both must be ignored.
  task automatic run_op(input logic o, input string tag, input int pulse_at);
    int tm_hi = 0, gap = 0, cyc = 0;
    start = 1'b1; op = o;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    while (!done && cyc < 3000) begin
      if (test_mode) tm_hi++;
      else if (busy) gap++;
      if (cyc == pulse_at) begin
        start = 1'b1; op = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; wr_en = 1'b0;
    mode = 2;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_tm_cycles"}, 32'(tm_hi), o ? 32'd1024 : 32'd512);
    check({tag, "_capture_cycles"}, 32'(gap), 32'(o));
    @(negedge clk);
    check({tag, "_done_sticky"}, 32'(done), 32'd1);
  endtask

  typedef struct {
    logic             op;
    int               mode;
    logic [REG_W-1:0] pat;
    logic [REG_W-1:0] base;
    logic [REG_W-1:0] xm;
    logic [REG_W-1:0] exp;
    logic             plus_i;
  } vec_t;

  vec_t tbl [4];

  initial begin
    tbl[0] = '{1'b0, 0, 32'h0,         32'hA5A5_0000, 32'h0,         32'hA5A5_0000, 1'b1};
    tbl[1] = '{1'b1, 1, 32'h0123_4567, 32'h0,         32'hFFFF_FFFF, 32'hFEDC_BA98, 1'b0};
    tbl[2] = '{1'b0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         1'b1};
    tbl[3] = '{1'b1, 1, 32'h0F0F_3C3C, 32'h0,         32'h00FF_FF00, 32'h0FF0_C33C, 1'b0};

    rst = 1'b1; start = 1'b0; op = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    for (int i = 0; i < NREG; i++) preset[i] = '0;

    // Reset with random inputs.
    for (int c = 0; c < 2; c++) begin
      start = 1'($urandom_range(0, 1)); op = 1'($urandom_range(0, 1));
      wr_en = 1'($urandom_range(0, 1)); wr_addr = AW'($urandom);
      wr_data = $urandom; rd_addr = AW'($urandom);
      @(negedge clk);
    end
    check("rst_test_mode", 32'(test_mode), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_scan_in", 32'(scan_in), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_sig", sig, 32'd0);
    rst = 1'b0; start = 1'b0; wr_en = 1'b0;
    @(negedge clk);

    // Table-driven operations.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NREG; i++) begin
        pat_w[i]  = tbl[t].pat;
        preset[i] = tbl[t].base + (tbl[t].plus_i ? 32'(i) : 32'd0);
        exp_w[i]  = tbl[t].exp  + (tbl[t].plus_i ? 32'(i) : 32'd0);
      end
      write_pattern();
      xmask = tbl[t].xm;
      mode  = tbl[t].mode;
      run_op(tbl[t].op, $sformatf("tbl%0d", t), -1);
      check_readback($sformatf("tbl%0d", t));
    end

    // Write coinciding with accepted start: op must use the new word 0.
    for (int i = 0; i < NREG; i++) begin
      pat_w[i] = 32'h1111_0000 + 32'(i);
      exp_w[i] = pat_w[i];
    end
    write_pattern();
    exp_w[0] = 32'hCAFE_F00D;
    xmask = '0; mode = 1;
    wr_en = 1'b1; wr_addr = '0; wr_data = 32'hCAFE_F00D;
    run_op(1'b1, "start_wr", -1);
    check_readback("start_wr");

    // start + write pulsed mid-SHIFT_OUT are ignored. The refilled chain is
    // then dumped unchanged to show pattern word 3 kept its value.
    for (int i = 0; i < NREG; i++) begin
      pat_w[i]  = $urandom;
      preset[i] = $urandom;
      exp_w[i]  = preset[i];
    end
    write_pattern();
    mode = 0;
    run_op(1'b0, "pulse", 200);
    check_readback("pulse");
    for (int i = 0; i < NREG; i++) exp_w[i] = pat_w[i];
    run_op(1'b0, "refill", -1);
    check_readback("refill");

    // Reset at SHIFT_OUT cycle 100, then a fresh DUMP.
    for (int i = 0; i < NREG; i++) begin
      preset[i] = $urandom;
      exp_w[i]  = preset[i];
    end
    mode = 0;
    start = 1'b1; op = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_test_mode", 32'(test_mode), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    run_op(1'b0, "after_abort", -1);
    check_readback("after_abort");

    // Randomized operations against the reference rules.
    for (int r = 0; r < 4; r++) begin
      logic o;
      o = 1'($urandom_range(0, 1));
      xmask = $urandom;
      for (int i = 0; i < NREG; i++) begin
        pat_w[i]  = $urandom;
        preset[i] = $urandom;
        exp_w[i]  = o ? (pat_w[i] ^ xmask) : preset[i];
      end
      write_pattern();
      mode = o ? 1 : 0;
      run_op(o, $sformatf("rand%0d", r), -1);
      check_readback($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
